sub_serial: RTL and testbench

Bit-serial subtractor computing `a - b` modulo 2^WIDTH, LSB first, one bit per clock. It is the inverse-operation counterpart of the serial adder: same `en`-driven start/acknowledge flow, same right-shifting result register. It sits next to the adder in the arithmetic datapath, so a sum can be checked or undone without a parallel subtractor.

---
 rtl/sub_serial_pkg.sv | 15 +
 rtl/sub_serial_fs_bit.sv | 15 +
 rtl/sub_serial.sv | 97 +++++++++
 tb/tb_sub_serial.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_serial_pkg.sv
// Shared constants for the bit-serial subtractor: state encodings, state width, default width.
// No logic; imported by the subtractor and its full-subtractor cell.
// Not applicable (package only).
package sub_serial_pkg;

    localparam int STATE_W       = 3;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        SUB  = 3'd1,
        DONE = 3'd2
    } state_e;

endpackage

// File: rtl/sub_serial_fs_bit.sv
// One-bit full subtractor: d = x - y - bin, bout set when the column needs a borrow.
// Purely combinational, zero latency.
// No handshake; evaluated every cycle by the parent.
module fs_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial a - b mod 2^WIDTH, LSB first; SUB_SERIAL_BORROW_EN adds the borrow_out port.
// Latency: WIDTH shift cycles after the start edge, then done holds until en acknowledges it.
// en starts in IDLE and acknowledges in DONE; it is ignored while shifting.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             done
`ifdef SUB_SERIAL_BORROW_EN
    ,
    output logic             borrow_out
`endif
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             borrow_q;
    logic             diff;
    logic             borrow_d;

    fs_bit u_fs_bit (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (borrow_q),
        .d    (diff),
        .bout (borrow_d)
    );

    // The new difference bit enters at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
    assign out_d   = {diff, out_q[WIDTH-1:1]};
    assign count_d = count_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            count_q  <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= 1'b0;
                        count_q  <= '0;
                        out_q    <= '0;
                        state_q  <= SUB;
                    end
                end
                SUB: begin
                    out_q    <= out_d;
                    borrow_q <= borrow_d;
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    count_q  <= count_d;
                    if (count_q == LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (en) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign done = (state_q == DONE);

`ifdef SUB_SERIAL_BORROW_EN
    assign borrow_out = (state_q == DONE) & borrow_q;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Bench for sub_serial: scoreboard of expected differences, one task per scenario.
module tb_sub_serial;
    import sub_serial_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         done;
`ifdef SUB_SERIAL_BORROW_EN
    logic         borrow_out;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
    } exp_t;

    exp_t sb[$];

    sub_serial #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .a    (a),
        .b    (b),
        .out  (out),
        .done (done)
`ifdef SUB_SERIAL_BORROW_EN
        ,
        .borrow_out (borrow_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.d  = x - y;
        e.bo = (x < y);
        sb.push_back(e);
    endtask

    task automatic start(input logic [W-1:0] x, input logic [W-1:0] y);
        a  = x;
        b  = y;
        en = 1'b1;
        push_exp(x, y);
        tick();
        en = 1'b0;
    endtask

    // Counts edges until done is seen; returns 40 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        a   = '0;
        b   = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (out !== 8'h00) begin
            errors++;
            $display("FAIL reset_out got %h want 00", out);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b want 0", done);
        end
`ifdef SUB_SERIAL_BORROW_EN
        checks++;
        if (borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_borrow got %b want 0", borrow_out);
        end
`endif
    endtask

    task automatic test_basic();
        int   cyc;
        exp_t e;
        start(8'd100, 8'd58);
        wait_done(cyc);
        checks++;
        if (cyc !== W) begin
            errors++;
            $display("FAIL basic_latency got %0d want %0d", cyc, W);
        end
        e = sb.pop_front();
        checks++;
        if (out !== e.d) begin
            errors++;
            $display("FAIL basic_out got %h want %h", out, e.d);
        end
`ifdef SUB_SERIAL_BORROW_EN
        checks++;
        if (borrow_out !== e.bo) begin
            errors++;
            $display("FAIL basic_borrow got %b want %b", borrow_out, e.bo);
        end
`endif
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack got %b want 0", done);
        end
    endtask

    task automatic test_borrow();
        logic [W-1:0] xs[2];
        logic [W-1:0] ys[2];
        int           cyc;
        exp_t         e;
        xs[0] = 8'd5; ys[0] = 8'd9;
        xs[1] = 8'd0; ys[1] = 8'd1;
        for (int i = 0; i < 2; i++) begin
            start(xs[i], ys[i]);
            wait_done(cyc);
            e = sb.pop_front();
            checks++;
            if (cyc !== W || out !== e.d) begin
                errors++;
                $display("FAIL borrow_out_%0d got %h (cyc %0d) want %h (cyc %0d)", i, out, cyc, e.d, W);
            end
`ifdef SUB_SERIAL_BORROW_EN
            checks++;
            if (borrow_out !== e.bo) begin
                errors++;
                $display("FAIL borrow_flag_%0d got %b want %b", i, borrow_out, e.bo);
            end
`endif
            en = 1'b1;
            tick();
            en = 1'b0;
        end
    endtask

    task automatic test_change_during_sub();
        int   cyc;
        exp_t e;
        start(8'hFF, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            tick();
        end
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (out !== e.d) begin
            errors++;
            $display("FAIL change_out got %h want %h", out, e.d);
        end
`ifdef SUB_SERIAL_BORROW_EN
        checks++;
        if (borrow_out !== e.bo) begin
            errors++;
            $display("FAIL change_borrow got %b want %b", borrow_out, e.bo);
        end
`endif
    endtask

    task automatic test_hold_done();
        logic [W-1:0] held;
        held = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out !== held || done !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d got out %h done %b want out %h done 1", i, out, done, held);
            end
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL hold_ack got %b want 0", done);
        end
        checks++;
        if (out !== held) begin
            errors++;
            $display("FAIL idle_hold_out got %h want %h", out, held);
        end
    endtask

    task automatic test_reset_mid();
        int   cyc;
        int   saw_done;
        exp_t e;
        start(8'd200, 8'd3);
        void'(sb.pop_back());
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out !== 8'h00 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst got out %h done %b want out 00 done 0", out, done);
        end
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) saw_done = 1;
        end
        checks++;
        if (saw_done !== 0) begin
            errors++;
            $display("FAIL midrst_idle got done seen %0d want 0", saw_done);
        end
        start(8'd20, 8'd7);
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc !== W || out !== e.d) begin
            errors++;
            $display("FAIL after_rst got %h (cyc %0d) want %h (cyc %0d)", out, cyc, e.d, W);
        end
    endtask

    task automatic test_bad_state();
        logic [W-1:0] held;
        held = out;
        force dut.state_q = state_e'(3'd5);
        #1;
        release dut.state_q;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL bad_state_done got %b want 0", done);
        end
        @(negedge clk);
        tick();
        checks++;
        if (out !== held || done !== 1'b0) begin
            errors++;
            $display("FAIL bad_state_next got out %h done %b want out %h done 0", out, done, held);
        end
    endtask

    task automatic test_back_to_back();
        int           cyc;
        exp_t         e;
        logic [W-1:0] x;
        logic [W-1:0] y;
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                x = 8'h00; y = 8'hFF;
            end else if (i == 1) begin
                x = 8'hFF; y = 8'h00;
            end else begin
                x = 8'($urandom_range(0, 255));
                y = 8'($urandom_range(0, 255));
            end
            a = x;
            b = y;
            push_exp(x, y);
            if (i > 0) tick();
            wait_done(cyc);
            e = sb.pop_front();
            checks++;
            if (cyc !== W + 1) begin
                errors++;
                $display("FAIL b2b_period_%0d got %0d want %0d", i, cyc + ((i > 0) ? 1 : 0), W + 1 + ((i > 0) ? 1 : 0));
            end
            checks++;
            if (out !== e.d) begin
                errors++;
                $display("FAIL b2b_out_%0d got %h want %h", i, out, e.d);
            end
`ifdef SUB_SERIAL_BORROW_EN
            checks++;
            if (borrow_out !== e.bo) begin
                errors++;
                $display("FAIL b2b_borrow_%0d got %b want %b", i, borrow_out, e.bo);
            end
`endif
        end
        en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        a   = '0;
        b   = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_borrow();
        test_change_during_sub();
        test_hold_done();
        test_reset_mid();
        test_bad_state();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
